// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: decodes SPI command words, owns the register bank and status, sequences tx responses.
module spi_reg_ctrl #(
    parameter int         NUM_REGS    = 8,
    parameter logic [7:0] REG_RESET   = 8'h00,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic [15:0]           i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_rx_error,
    input  logic                  i_tx_ready,
    input  logic                  i_tx_error,
    output logic [15:0]           o_tx_data,
    output logic                  o_tx_load,
    output logic [NUM_REGS*8-1:0] o_regs,
    output logic [7:0]            o_status,
    output logic                  o_busy
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] NR = 8'(NUM_REGS);
    typedef enum logic [2:0] {IDLE, DECODE, WRITE, READ, ERR, WAIT_TX} state_t;
    state_t state_q, state_d;
    logic [15:0] cmd_q, cmd_d, tx_q, tx_d, tx_resp;
    logic [7:0] reg_q [NUM_REGS];
    logic [7:0] reg_d [NUM_REGS];
    logic [7:0] status_q, status_d, base, rd_val;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0] addr;
    logic [3:0] err_bits;
    logic addr_ok, timeout, tx_load, clr;
    assign addr    = cmd_q[14:8];
    assign addr_ok = ({1'b0, addr} < NR) || (addr == 7'h7F);
    assign timeout = state_q == WAIT_TX && !i_tx_ready && cnt_q == TMAX;
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            tx_q     <= '0;
            status_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) reg_q[i] <= REG_RESET;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            tx_q     <= tx_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
            reg_q    <= reg_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:              state_d = (i_rx_valid && !i_rx_error) ? DECODE : IDLE;
            DECODE:            state_d = !addr_ok ? ERR : cmd_q[15] ? READ : WRITE;
            WRITE, READ, ERR:  state_d = WAIT_TX;
            WAIT_TX:           state_d = (i_tx_ready || timeout) ? IDLE : WAIT_TX;
            default:           state_d = IDLE;
        endcase
    end
    always_comb begin
        rd_val = status_q;
        reg_d  = reg_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == 7'(i)) rd_val = reg_q[i];
            if (state_q == WRITE && addr == 7'(i)) reg_d[i] = cmd_q[7:0];
        end
        tx_load = state_q == WRITE || state_q == READ || state_q == ERR;
        tx_resp = state_q == ERR ? 16'hFEEE : state_q == READ ? {1'b1, addr, rd_val} : {1'b0, addr, cmd_q[7:0]};
        // Response is driven combinationally in the load cycle, then held in tx_q.
        tx_d    = tx_load ? tx_resp : tx_q;
        cmd_d   = (state_q == IDLE && i_rx_valid && !i_rx_error) ? i_rx_data : cmd_q;
        cnt_d   = (state_q == WAIT_TX && !i_tx_ready && !timeout) ? cnt_q + 1'b1 : '0;
        clr     = state_q == READ && addr == 7'h7F;
        base    = clr ? 8'h00 : status_q;
        err_bits = {i_rx_valid && state_q != IDLE, state_q == ERR, i_rx_error, i_tx_error || timeout};
        status_d = {base[7:4] | err_bits, base[3:0] + {3'b000, (|err_bits) && base[3:0] != 4'hF}};
    end
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign o_regs[8*g +: 8] = reg_q[g];
    end
    assign o_tx_load = tx_load;
    assign o_tx_data = tx_d;
    assign o_status  = status_q;
    assign o_busy    = state_q != IDLE;
endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
Command controller that sequences the 16-bit SPI slave word interface and owns the MCU-visible configuration register bank. It decodes each received word as a read or write, updates the register bank, loads the response word into the slave's transmit path, and tracks protocol errors in a status register. It sits between the SPI slave and the LEDs and generator configuration logic.

Parameters:
NUM_REGS, 8, number of 8-bit R/W registers; addresses 0..NUM_REGS-1; legal range 1..127.
REG_RESET, 8'h00, reset value of every R/W register.
TIMEOUT_CYC, 1024, maximum i_sys_clk cycles spent in WAIT_TX before abandoning; counter width is clog2(TIMEOUT_CYC+1).

Ports:
i_sys_clk  in  1  system clock; all logic on rising edge.
i_sys_rst  in  1  synchronous, active-high reset.
i_rx_data  in  16  received word from the SPI slave.
i_rx_valid  in  1  one-cycle pulse; i_rx_data is valid in that cycle.
i_rx_error  in  1  one-cycle pulse: slave receive error.
i_tx_ready  in  1  level: slave has consumed the loaded tx word and can take the next.
i_tx_error  in  1  one-cycle pulse: slave transmit error.
o_tx_data  out  16  response word presented to the slave.
o_tx_load  out  1  one-cycle pulse: the slave latches o_tx_data.
o_regs  out  NUM_REGS*8  flattened register bank; reg n is at bits [8n+7:8n].
o_status  out  8  live copy of the status register.
o_busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Word format: [15] 1=read, 0=write; [14:8] address; [7:0] write data (ignored for reads).
- Reset: state=IDLE; o_tx_data=16'h0000; o_tx_load=0; all regs=REG_RESET; o_status=0; o_busy=0; timeout counter=0. Reset overrides everything, including mid-transaction; no response is issued.
- FSM states: IDLE, DECODE, WRITE, READ, ERR, WAIT_TX.
- IDLE: if i_rx_valid=1 and i_rx_error=0, latch i_rx_data and go to DECODE. If both are high in the same cycle, drop the word and record an rx error.
- DECODE (1 cycle):
  - addr < NUM_REGS or addr = 7'h7F: go to WRITE if bit15=0, READ if bit15=1.
  - Any other address: go to ERR.
- WRITE (1 cycle):
  - addr < NUM_REGS: reg[addr] <= data.
  - addr = 7'h7F: no register change and no error.
  - In both cases: o_tx_data <= {1'b0, addr, data}, o_tx_load=1, then go to WAIT_TX.
- READ (1 cycle):
  - o_tx_data <= {1'b1, addr, value}, o_tx_load=1, then go to WAIT_TX.
  - value = reg[addr], or the status register when addr = 7'h7F.
  - Reading 7'h7F clears the status register in the same cycle (read-to-clear).
- ERR (1 cycle): o_tx_data <= {8'hE0 | {1'b0, addr[6:0]}>>0 ... } is not used; instead o_tx_data <= {1'b1, 7'h7E, 8'hEE}, o_tx_load=1, set the addr-error bit, then go to WAIT_TX.
- WAIT_TX: the counter increments each cycle.
  - i_tx_ready=1: clear the counter and go to IDLE.
  - Counter reaches TIMEOUT_CYC-1: set the tx-error bit, clear the counter, go to IDLE.
- Command-to-load latency: i_rx_valid at cycle N gives o_tx_load at cycle N+2 and the register update visible on o_regs at N+3.
- Status register:
  - [7] overrun: i_rx_valid seen in any state other than IDLE; the word is discarded.
  - [6] address error.
  - [5] rx error: i_rx_error seen in any state.
  - [4] tx error: i_tx_error or WAIT_TX timeout.
  - [3:0] error count, saturating at 15.
  - Bits [7:4] are sticky until a read of 7'h7F.
- Count rule: the count increments by at most 1 per cycle, however many error sources fire in that cycle.
- Simultaneous clear and error: if a status read-clear coincides with a new error, the new error's bit is set and the count is 1.
- o_tx_load is never high in two consecutive cycles. o_tx_data holds its value between loads.

Test Plan:
- Reset, then write 16'h0255 -> o_tx_load at +2 with o_tx_data=16'h0255; at +3, o_regs[23:16]=8'h55; o_status=0.
- After the previous step, read 16'h8200 -> o_tx_data=16'h8255, o_tx_load pulse; hold i_tx_ready=1 -> back in IDLE, o_busy=0.
- Write to address 0x10 with NUM_REGS=8 -> o_tx_data=16'hFEEE; o_status=8'h41; no register changes.
- Send a second i_rx_valid one cycle after the first -> second word dropped; o_status[7]=1, count=1. Then read 16'hFF00 -> o_tx_data[7:0]=8'h81 and o_status=0 the next cycle.
- Hold i_tx_ready=0 after any command -> return to IDLE after TIMEOUT_CYC cycles; o_status=8'h11. Then assert 20 error events -> count saturates at 4'hF.
- Assert i_sys_rst while in WAIT_TX -> next cycle: IDLE, regs=REG_RESET, o_status=0, o_tx_load=0.
